word_byte_ser: RTL and testbench

WORD_BYTE_SER -- requirements
Module: word_byte_ser

---
 rtl/word_byte_ser_pkg.sv | 26 ++
 rtl/word_byte_ser_phase_timer.sv | 35 +++
 rtl/word_byte_ser.sv | 169 ++++++++++++++++
 tb/tb_word_byte_ser.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_byte_ser_pkg.sv
// ============================================================================
// Module : word_byte_ser_pkg
// Desc   : Shared state encoding, index width and counter sizing helper for
//          the word-to-byte serialiser.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package word_byte_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int IDX_W = 4;

    // Bits needed for a down-counter that is loaded with (n-1) and runs to 0.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_byte_ser_phase_timer.sv
// ============================================================================
// Module : ser_phase_timer
// Desc   : Loadable down-counter timing one STROBE or GAP phase; o_done is
//          high in the final cycle of the phase.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_phase_timer #(
    parameter int W = 1
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/word_byte_ser.sv
// ============================================================================
// Module : word_byte_ser
// Desc   : Serialises an NOF_BYTES-byte word into strobed bytes with fixed
//          strobe/gap timing. Define WORD_BYTE_SER_CKSUM_EN to append an XOR
//          checksum byte after the data bytes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_byte_ser
    import word_byte_ser_pkg::*;
#(
    parameter int NOF_BYTES     = 3,
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic [8*NOF_BYTES-1:0] din,
    input  logic                   in_valid,
    input  logic                   lsb_first,
    output logic                   in_ready,
    output logic [7:0]             dout,
    output logic                   dout_strobe,
    output logic [IDX_W-1:0]       byte_idx,
    output logic                   busy
);

    localparam int MAX_PHASE = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = cnt_width(MAX_PHASE);
`ifdef WORD_BYTE_SER_CKSUM_EN
    localparam int LAST_IDX  = NOF_BYTES;
`else
    localparam int LAST_IDX  = NOF_BYTES - 1;
`endif
    localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(LAST_IDX);
    localparam logic [CNT_W-1:0] C_S_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_G_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [8*NOF_BYTES-1:0] r_word;
    logic                   r_lsb;
    logic [IDX_W-1:0]       r_idx;
    logic [7:0]             r_dout;
    logic                   w_load;
    logic [CNT_W-1:0]       w_load_val;
    logic                   w_done;
    logic                   w_accept;
    logic                   w_adv;
    logic [IDX_W-1:0]       w_nidx;
    logic [7:0]             w_nbyte;

    // Position 0 is the first byte on the wire; lsb selects the direction.
    function automatic logic [7:0] sel_byte(input logic [8*NOF_BYTES-1:0] word,
                                            input logic lsb,
                                            input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        int         pos;
        b   = '0;
        pos = lsb ? int'(idx) : (NOF_BYTES - 1 - int'(idx));
        for (int k = 0; k < NOF_BYTES; k++) begin
            if (pos == k) b = word[8*k +: 8];
        end
        return b;
    endfunction

    ser_phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .pclk       (pclk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = C_S_LOAD;
        w_accept   = 1'b0;
        w_adv      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    w_next   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = C_G_LOAD;
                    w_next     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_done) begin
                    if (r_idx == C_LAST) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_adv  = 1'b1;
                        w_load = 1'b1;
                        w_next = ST_STROBE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_nidx = r_idx + IDX_W'(1);

`ifdef WORD_BYTE_SER_CKSUM_EN
    logic [7:0] r_cksum;

    function automatic logic [7:0] xor_bytes(input logic [8*NOF_BYTES-1:0] word);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < NOF_BYTES; k++) x = x ^ word[8*k +: 8];
        return x;
    endfunction

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_cksum <= '0;
        end else if (w_accept) begin
            r_cksum <= xor_bytes(din);
        end
    end

    assign w_nbyte = (w_nidx == IDX_W'(NOF_BYTES)) ? r_cksum : sel_byte(r_word, r_lsb, w_nidx);
`else
    assign w_nbyte = sel_byte(r_word, r_lsb, w_nidx);
`endif

    // dout is loaded only at byte boundaries so it holds through STROBE, GAP and IDLE.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_lsb   <= 1'b0;
            r_idx   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_word <= din;
                r_lsb  <= lsb_first;
                r_idx  <= '0;
                r_dout <= sel_byte(din, lsb_first, '0);
            end else if (w_adv) begin
                r_idx  <= w_nidx;
                r_dout <= w_nbyte;
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = ~in_ready;
    assign dout_strobe = (r_state == ST_STROBE);
    assign dout        = r_dout;
    assign byte_idx    = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_word_byte_ser.sv
// ============================================================================
// Module : tb_word_byte_ser
// Desc   : Self-checking bench for word_byte_ser (3/1/1 and 2/3/2 instances);
//          honours WORD_BYTE_SER_CKSUM_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_word_byte_ser;

`ifdef WORD_BYTE_SER_CKSUM_EN
    localparam int E = 1;
`else
    localparam int E = 0;
`endif

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    logic [23:0] a_din;  logic a_valid, a_lsb;
    logic        a_ready, a_stb, a_busy;  logic [7:0] a_dout;  logic [3:0] a_idx;
    logic [15:0] b_din;  logic b_valid, b_lsb;
    logic        b_ready, b_stb, b_busy;  logic [7:0] b_dout;  logic [3:0] b_idx;

    word_byte_ser #(.NOF_BYTES(3), .STROBE_CYCLES(1), .GAP_CYCLES(1)) u_dut_a (
        .pclk(pclk), .rst(rst), .din(a_din), .in_valid(a_valid), .lsb_first(a_lsb),
        .in_ready(a_ready), .dout(a_dout), .dout_strobe(a_stb), .byte_idx(a_idx), .busy(a_busy));

    word_byte_ser #(.NOF_BYTES(2), .STROBE_CYCLES(3), .GAP_CYCLES(2)) u_dut_b (
        .pclk(pclk), .rst(rst), .din(b_din), .in_valid(b_valid), .lsb_first(b_lsb),
        .in_ready(b_ready), .dout(b_dout), .dout_strobe(b_stb), .byte_idx(b_idx), .busy(b_busy));

    function automatic int nb(input int d); return (d == 0) ? 3 : 2; endfunction
    function automatic int sc(input int d); return (d == 0) ? 1 : 3; endfunction
    function automatic int gc(input int d); return (d == 0) ? 1 : 2; endfunction

    typedef struct packed { logic [7:0] dout; logic stb; logic [3:0] idx; } exp_t;
    typedef struct { logic [7:0] dout; logic [3:0] idx; int off; } ev_t;

    exp_t       mq[2][$];
    ev_t        slog[2][$];
    logic [7:0] m_last[2];
    logic [3:0] m_lidx[2];
    int         acc_cyc[2], rdy_off[2], busy_cnt[2], stb_cnt[2];
    bit         prev_stb[2], prev_rdy[2];
    int         acc_list[$];
    int         cyc = 0;
    int         checks = 0, errors = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected per-cycle timeline of one word: each byte is S strobe cycles then G gap cycles.
    task automatic model_accept(input int d, input logic [63:0] w, input logic lsb);
        logic [7:0] bytes[$];
        logic [7:0] x, bb;
        x = 8'h00;
        for (int k = 0; k < nb(d); k++) begin
            bb = lsb ? w[8*k +: 8] : w[8*(nb(d)-1-k) +: 8];
            bytes.push_back(bb);
            x = x ^ bb;
        end
        if (E == 1) bytes.push_back(x);
        for (int k = 0; k < bytes.size(); k++) begin
            for (int s = 0; s < sc(d); s++) mq[d].push_back('{bytes[k], 1'b1, 4'(k)});
            for (int g = 0; g < gc(d); g++) mq[d].push_back('{bytes[k], 1'b0, 4'(k)});
        end
    endtask

    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t        e;
            logic        eb, ar, ab, as, iv, il;
            logic [3:0]  ai;
            logic [7:0]  ad;
            logic [63:0] idin;
            if (d == 0) begin
                {ar, ab, as, ai, ad} = {a_ready, a_busy, a_stb, a_idx, a_dout};
                {iv, il} = {a_valid, a_lsb};  idin = 64'(a_din);
            end else begin
                {ar, ab, as, ai, ad} = {b_ready, b_busy, b_stb, b_idx, b_dout};
                {iv, il} = {b_valid, b_lsb};  idin = 64'(b_din);
            end
            if (rst) begin
                mq[d].delete();
                m_last[d] = 8'h00;  m_lidx[d] = 4'd0;
                eb = 1'b0;  e = '{8'h00, 1'b0, 4'd0};
            end else if (mq[d].size() > 0) begin
                e  = mq[d].pop_front();
                eb = 1'b1;
                if (mq[d].size() == 0) begin
                    m_last[d] = e.dout;  m_lidx[d] = e.idx;
                end
            end else begin
                eb = 1'b0;  e = '{m_last[d], 1'b0, m_lidx[d]};
            end
            check((d == 0) ? "cycle_a" : "cycle_b", {ar, ab, as, ai, ad}, {~eb, eb, e.stb, e.idx, e.dout});
            if (as && !prev_stb[d]) slog[d].push_back('{ad, ai, cyc - acc_cyc[d]});
            if (ar && !prev_rdy[d]) rdy_off[d] = cyc - acc_cyc[d];
            busy_cnt[d] += int'(ab);
            stb_cnt[d]  += int'(as);
            prev_stb[d] = as;
            prev_rdy[d] = ar;
            if (!rst && !eb && iv) begin
                model_accept(d, idin, il);
                acc_cyc[d] = cyc;
                if (d == 0) acc_list.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_logs(input int d);
        slog[d].delete();
        busy_cnt[d] = 0;  stb_cnt[d] = 0;  rdy_off[d] = -1;
    endtask

    task automatic wait_idle(input int d, input string nm);
        int n;
        n = 0;
        tick();
        while (!((d == 0) ? a_ready : b_ready) && n < 200) begin
            tick();
            n++;
        end
        check({nm, "_timeout"}, 64'(n < 200), 64'd1);
        tick();
    endtask

    task automatic send_a(input logic [23:0] w, input logic lsb);
        a_din = w;  a_lsb = lsb;  a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] w, input logic lsb);
        b_din = w;  b_lsb = lsb;  b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic chk_ev(input int d, input int k, input logic [7:0] bv, input int off, input string nm);
        if (slog[d].size() > k) begin
            check({nm, "_byte"}, 64'(slog[d][k].dout), 64'(bv));
            check({nm, "_off"}, 64'(slog[d][k].off), 64'(off));
        end else begin
            check({nm, "_missing"}, 64'(slog[d].size()), 64'(k + 1));
        end
    endtask

    initial begin
        int c33, n;
        a_din = '0;  a_valid = 1'b0;  a_lsb = 1'b0;
        b_din = '0;  b_valid = 1'b0;  b_lsb = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_a_outputs", {a_ready, a_busy, a_stb, a_idx, a_dout}, {1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        check("rst_b_outputs", {b_ready, b_busy, b_stb, b_idx, b_dout}, {1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        rst = 1'b0;
        tick();

        // MSB-first word on the 3/1/1 instance
        clear_logs(0);
        send_a(24'hA1B2C3, 1'b0);
        wait_idle(0, "t1");
        check("t1_count", 64'(slog[0].size()), 64'(3 + E));
        chk_ev(0, 0, 8'hA1, 1, "t1_b0");
        chk_ev(0, 1, 8'hB2, 3, "t1_b1");
        chk_ev(0, 2, 8'hC3, 5, "t1_b2");
        check("t1_ready_off", 64'(rdy_off[0]), 64'(7 + 2*E));
        check("t1_idle_dout", 64'(a_dout), (E == 1) ? 64'hD0 : 64'hC3);

        // LSB-first, same word
        clear_logs(0);
        send_a(24'hA1B2C3, 1'b1);
        wait_idle(0, "t2");
        chk_ev(0, 0, 8'hC3, 1, "t2_b0");
        chk_ev(0, 1, 8'hB2, 3, "t2_b1");
        chk_ev(0, 2, 8'hA1, 5, "t2_b2");

        // Longer strobe/gap on the 2/3/2 instance
        clear_logs(1);
        send_b(16'h5A0F, 1'b0);
        wait_idle(1, "t3");
        chk_ev(1, 0, 8'h5A, 1, "t3_b0");
        chk_ev(1, 1, 8'h0F, 6, "t3_b1");
        check("t3_busy_cycles", 64'(busy_cnt[1]), 64'(10 + 5*E));
        check("t3_strobe_cycles", 64'(stb_cnt[1]), 64'(6 + 3*E));
        check("t3_ready_off", 64'(rdy_off[1]), 64'(11 + 5*E));

        // Reset during the second byte, then a clean word
        clear_logs(0);
        send_a(24'h112233, 1'b0);
        n = 0;
        while (a_idx != 4'd1 && n < 20) begin
            tick();
            n++;
        end
        check("t4_reached_b1", 64'(a_idx), 64'd1);
        rst = 1'b1;
        #1;
        check("t4_rst_async", {a_ready, a_busy, a_stb, a_idx, a_dout}, {1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tick();
        rst = 1'b0;
        repeat (8) tick();
        c33 = 0;
        foreach (slog[0][k]) if (slog[0][k].dout == 8'h33) c33++;
        check("t4_no_33", 64'(c33), 64'd0);
        check("t4_strobes_before_rst", 64'(slog[0].size()), 64'd1);
        clear_logs(0);
        send_a(24'h445566, 1'b0);
        wait_idle(0, "t4b");
        chk_ev(0, 0, 8'h44, 1, "t4b_b0");
        chk_ev(0, 1, 8'h55, 3, "t4b_b1");
        chk_ev(0, 2, 8'h66, 5, "t4b_b2");

        // in_valid held high while busy with din changing every cycle
        clear_logs(0);
        acc_list.delete();
        a_lsb = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            if (j == 0)              a_din = 24'h102030;
            else if (j == 7 + 2*E)   a_din = 24'h778899;
            else                     a_din = 24'hDEAD00 + 24'(j);
            a_valid = 1'b1;
            tick();
        end
        a_valid = 1'b0;
        wait_idle(0, "t5");
        check("t5_accepts", 64'(acc_list.size()), 64'd2);
        if (acc_list.size() >= 2)
            check("t5_accept_gap", 64'(acc_list[1] - acc_list[0]), 64'(7 + 2*E));
        chk_ev(0, 0, 8'h10, 1, "t5_w0b0");
        chk_ev(0, 1, 8'h20, 3, "t5_w0b1");
        chk_ev(0, 2, 8'h30, 5, "t5_w0b2");
        chk_ev(0, 3 + E, 8'h77, 1, "t5_w1b0");
        chk_ev(0, 4 + E, 8'h88, 3, "t5_w1b1");
        chk_ev(0, 5 + E, 8'h99, 5, "t5_w1b2");

`ifdef WORD_BYTE_SER_CKSUM_EN
        clear_logs(0);
        send_a(24'h0F3CF0, 1'b0);
        wait_idle(0, "t6");
        chk_ev(0, 3, 8'hC3, 7, "t6_cksum");
        if (slog[0].size() > 3)
            check("t6_cksum_idx", 64'(slog[0][3].idx), 64'd3);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
